// File: rtl/rst_seq_ctrl.sv
// rtl/rst_seq_ctrl.sv - reset sequencer: hold all domains, release in index order, sticky cause
module rst_seq_ctrl #(
  parameter int NUM_DOM  = 4,
  parameter int CNT_W    = 8,
  parameter int HOLD_CYC = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     sw_rst_req_i,
  input  logic                     wdt_rst_req_i,
  input  logic                     prog_rst_ni,
  input  logic [NUM_DOM*CNT_W-1:0] dom_delay_i,
  input  logic                     cause_clr_i,
  output logic [NUM_DOM-1:0]       dom_rst_no,
  output logic                     busy_o,
  output logic [3:0]               rst_cause_o
);

  localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    REL  = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_DOM-1:0] dom_q, dom_d;
  logic               busy_q, busy_d;
  logic [3:0]         cause_q, cause_d;

  logic               req;
  logic [CNT_W-1:0]   cnt_inc;
  logic [CNT_W-1:0]   cur_delay;

  // Any of these drops every domain back into reset; programmer reset is a level.
  assign req = sw_rst_req_i | wdt_rst_req_i | ~prog_rst_ni;

  // The counter saturates so a huge hold or delay can never wrap into an early match.
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  // Pick the live release delay of the domain currently being sequenced.
  always_comb begin
    cur_delay = '0;
    for (int k = 0; k < NUM_DOM; k++) begin
      if (idx_q == IDX_W'(k)) cur_delay = dom_delay_i[k*CNT_W +: CNT_W];
    end
  end

  // Next-state, counter, release mask and cause logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;

    // A request in the same cycle as a clear survives the clear.
    cause_d = cause_clr_i ? 4'b0000 : cause_q;
    cause_d = cause_d | {~prog_rst_ni, wdt_rst_req_i, sw_rst_req_i, 1'b0};

    case (state_q)
      HOLD: begin
        dom_d = '0;
        if (req) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
          state_d = REL;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      REL: begin
        if (req) begin
          state_d = HOLD;
          dom_d   = '0;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == cur_delay) begin
          for (int k = 0; k < NUM_DOM; k++) begin
            if (idx_q == IDX_W'(k)) dom_d[k] = 1'b1;
          end
          cnt_d = '0;
          if (idx_q == IDX_W'(NUM_DOM - 1)) begin
            state_d = RUN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RUN: begin
        dom_d = '1;
        if (req) begin
          state_d = HOLD;
          dom_d   = '0;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = HOLD;
        dom_d   = '0;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    busy_d = (state_d != RUN);
  end

  // State and registered outputs; power-on reset records the POR cause.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      busy_q  <= 1'b1;
      cause_q <= 4'b0001;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      busy_q  <= busy_d;
      cause_q <= cause_d;
    end
  end

  assign dom_rst_no  = dom_q;
  assign busy_o      = busy_q;
  assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb/tb_rst_seq_ctrl.sv - scoreboard bench for rst_seq_ctrl
module tb_rst_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sw;
  logic        wdt;
  logic        prog_n;
  logic        clr;
  logic [31:0] delays;
  logic [3:0]  dom;
  logic        busy;
  logic [3:0]  cause;

  rst_seq_ctrl #(.NUM_DOM(4), .CNT_W(8), .HOLD_CYC(16)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .sw_rst_req_i  (sw),
    .wdt_rst_req_i (wdt),
    .prog_rst_ni   (prog_n),
    .dom_delay_i   (delays),
    .cause_clr_i   (clr),
    .dom_rst_no    (dom),
    .busy_o        (busy),
    .rst_cause_o   (cause)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int       c;
    logic [3:0] dom;
    logic       busy;
    logic [3:0] cause;
  } ev_t;

  ev_t        q[$];
  ev_t        mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_cause;
  logic [8:0] prev = 9'b0000_1_0001;
  int         h;
  int         c0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [3:0] d, input logic b, input logic [3:0] ca);
    q.push_back('{c, d, b, ca});
  endtask

  // Expected release events, relative to the cycle the hold counter starts at 0.
  task automatic push_seq(input int hs, input int n);
    int         off[4] = '{20, 21, 24, 26};
    logic [3:0] pat[4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    for (int i = 0; i < n; i++) push(hs + off[i], pat[i], (i == 3) ? 1'b0 : 1'b1, exp_cause);
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: every output change must match the next expected event, at the expected cycle.
  always @(negedge clk) begin
    if ({dom, busy, cause} !== prev) begin
      prev <= {dom, busy, cause};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d dom=%b busy=%b cause=%b", cyc, dom, busy, cause);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.c != cyc || mon_e.dom !== dom || mon_e.busy !== busy || mon_e.cause !== cause) begin
          errors++;
          $display("FAIL event actual cyc=%0d dom=%b busy=%b cause=%b required cyc=%0d dom=%b busy=%b cause=%b",
                   cyc, dom, busy, cause, mon_e.c, mon_e.dom, mon_e.busy, mon_e.cause);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    sw        = 1'b0;
    wdt       = 1'b0;
    prog_n    = 1'b1;
    clr       = 1'b0;
    delays    = {8'd1, 8'd2, 8'd0, 8'd3};
    exp_cause = 4'b0001;

    #2;
    chk("reset_dom", dom, 4'b0000);
    chk("reset_busy", busy, 1'b1);
    chk("reset_cause", cause, 4'b0001);

    // Power-on sequence.
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    h   = cyc;
    push_seq(h, 4);
    wait_to(h + 16);
    chk("hold_end_dom", dom, 4'b0000);
    chk("hold_end_busy", busy, 1'b1);
    wait_to(h + 28);

    // Watchdog request in RUN.
    wdt       = 1'b1;
    exp_cause = exp_cause | 4'b0100;
    push(cyc + 1, 4'b0000, 1'b1, exp_cause);
    h = cyc + 1;
    push_seq(h, 4);
    @(negedge clk);
    wdt = 1'b0;
    wait_to(h + 28);

    // Programmer reset held low for 40 cycles.
    prog_n    = 1'b0;
    exp_cause = exp_cause | 4'b1000;
    push(cyc + 1, 4'b0000, 1'b1, exp_cause);
    c0 = cyc;
    wait_to(c0 + 40);
    prog_n = 1'b1;
    h      = cyc;
    push_seq(h, 2);
    wait_to(h + 22);

    // Software request aborts REL after domain 1 is released.
    sw        = 1'b1;
    exp_cause = exp_cause | 4'b0010;
    push(cyc + 1, 4'b0000, 1'b1, exp_cause);
    h = cyc + 1;
    push_seq(h, 4);
    @(negedge clk);
    sw = 1'b0;
    wait_to(h + 28);

    // Clear coinciding with sw+wdt requests: the requests are kept.
    sw        = 1'b1;
    wdt       = 1'b1;
    clr       = 1'b1;
    exp_cause = 4'b0110;
    push(cyc + 1, 4'b0000, 1'b1, exp_cause);
    h = cyc + 1;
    push_seq(h, 2);
    @(negedge clk);
    sw  = 1'b0;
    wdt = 1'b0;
    clr = 1'b0;
    wait_to(h + 22);

    // Asynchronous reset mid-REL.
    #2;
    exp_cause = 4'b0001;
    push(cyc + 1, 4'b0000, 1'b1, exp_cause);
    rst = 1'b1;
    #1;
    chk("async_dom", dom, 4'b0000);
    chk("async_busy", busy, 1'b1);
    chk("async_cause", cause, 4'b0001);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    h   = cyc;
    push_seq(h, 4);
    wait_to(h + 30);

    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
